// File: rtl/bk_pipe_adder.sv
// -----------------------------------------------------------------------------
// bk_pipe_adder
//
// Pipelined Brent-Kung parallel-prefix adder/subtractor with valid/ready flow
// control. It computes {cout, sum} = A + (sub ? ~B : B) + (sub ? 1 : cin) for any
// power-of-two WIDTH from 4 to 64. It also reports two's-complement signed
// overflow. Three register stages give a latency of 3 cycles and a throughput of
// one beat per cycle. Up to 3 beats are buffered under backpressure.
//
// Parameters
//   WIDTH      operand width, power of two in 4..64
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset (clears all valid bits and outputs)
//   in_valid   operand beat offered
//   in_ready   pipeline accepts the operand beat this cycle
//   in_a       operand A
//   in_b       operand B
//   in_cin     carry-in, ignored when in_sub = 1
//   in_sub     0: A + B + cin, 1: A - B
//   out_valid  result beat valid
//   out_ready  consumer accepts the result beat
//   out_sum    sum/difference modulo 2^WIDTH
//   out_cout   carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   out_ovf    signed overflow, c[WIDTH] ^ c[WIDTH-1]
// -----------------------------------------------------------------------------
module bk_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int LOG2 = $clog2(WIDTH);

    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("bk_pipe_adder: WIDTH must be a power of two between 4 and 64");
    end

    // Up-sweep level l combines node i with node i - 2^l wherever i + 1 is a
    // multiple of 2^(l+1). After all levels, node 2^k-1 holds the group
    // generate/propagate of bits [2^k-1:0].
    function automatic logic [WIDTH-1:0] up_mask(input int l);
        logic [WIDTH-1:0] m;
        int               step;
        m    = '0;
        step = 2 << l;
        for (int i = 0; i < WIDTH; i++) begin
            if (((i + 1) % step) == 0) begin
                m = m | (WIDTH'(1) << i);
            end
        end
        return m;
    endfunction

    // Down-sweep level l fills in the nodes halfway between the up-sweep nodes.
    // Node i is combined with node i - 2^l, which is already a complete prefix.
    function automatic logic [WIDTH-1:0] dn_mask(input int l);
        logic [WIDTH-1:0] m;
        int               step;
        m    = '0;
        step = 2 << l;
        for (int i = 0; i < WIDTH; i++) begin
            if ((((i + 1) % step) == (1 << l)) && ((i + 1) > step)) begin
                m = m | (WIDTH'(1) << i);
            end
        end
        return m;
    endfunction

    // One prefix level applied to a whole vector. Bit i of (x << d) is bit
    // i - d of x, so the masked bits take the (G,P) pair from 2^l positions lower.
    function automatic logic [2*WIDTH-1:0] prefix_level(
        input logic [WIDTH-1:0] g,
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] m,
        input int               d
    );
        logic [WIDTH-1:0] g_o;
        logic [WIDTH-1:0] p_o;
        g_o = g | (m & p & (g << d));
        p_o = (p & ~m) | (m & p & (p << d));
        return {p_o, g_o};
    endfunction

    // Flow control: a stage may load when it is empty or its beat moves on.
    logic vld_p1, vld_p2, vld_p3;
    logic en_p1, en_p2, en_p3;
    logic acc;

    assign en_p3     = !vld_p3 || out_ready;
    assign en_p2     = !vld_p2 || en_p3;
    assign en_p1     = !vld_p1 || en_p2;
    assign in_ready  = en_p1;
    assign acc       = in_valid && en_p1;
    assign out_valid = vld_p3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else begin
            if (en_p1) vld_p1 <= in_valid;
            if (en_p2) vld_p2 <= vld_p1;
            if (en_p3) vld_p3 <= vld_p2;
        end
    end

    // ---- Stage 1: operand conditioning, bitwise generate/propagate ----
    logic [WIDTH-1:0] b_x;
    logic             c0_x;
    logic [WIDTH-1:0] g_p1, p_p1;
    logic             c0_p1;

    assign b_x  = in_sub ? ~in_b : in_b;
    assign c0_x = in_sub | in_cin;

    always_ff @(posedge clk) begin
        if (acc) begin
            g_p1  <= in_a & b_x;
            p_p1  <= in_a ^ b_x;
            c0_p1 <= c0_x;
        end
    end

    // ---- Stage 2: up-sweep of the prefix tree ----
    logic [WIDTH-1:0]   ug, up;
    logic [2*WIDTH-1:0] up_lvl;

    always_comb begin
        ug     = g_p1;
        up     = p_p1;
        up_lvl = '0;
        for (int l = 0; l < LOG2; l++) begin
            up_lvl = prefix_level(ug, up, up_mask(l), 1 << l);
            ug     = up_lvl[WIDTH-1:0];
            up     = up_lvl[2*WIDTH-1:WIDTH];
        end
    end

    logic [WIDTH-1:0] gg_p2, gp_p2, p_p2;
    logic             c0_p2;

    always_ff @(posedge clk) begin
        if (en_p2 && vld_p1) begin
            gg_p2 <= ug;
            gp_p2 <= up;
            p_p2  <= p_p1;     // the bitwise propagate is still needed for the sum
            c0_p2 <= c0_p1;
        end
    end

    // ---- Stage 3: down-sweep, carries, sum and flags ----
    logic [WIDTH-1:0]   dg, dp;
    logic [2*WIDTH-1:0] dn_lvl;
    logic [WIDTH:0]     c;

    always_comb begin
        dg     = gg_p2;
        dp     = gp_p2;
        dn_lvl = '0;
        for (int l = LOG2 - 2; l >= 0; l--) begin
            dn_lvl = prefix_level(dg, dp, dn_mask(l), 1 << l);
            dg     = dn_lvl[WIDTH-1:0];
            dp     = dn_lvl[2*WIDTH-1:WIDTH];
        end
        // c[i+1] = G[i:0] | P[i:0] & c0; c[0] is the injected carry.
        c = {dg | (dp & {WIDTH{c0_p2}}), c0_p2};
    end

    logic signed [WIDTH-1:0] sum_p3;
    logic                    cout_p3, ovf_p3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p3  <= '0;
            cout_p3 <= 1'b0;
            ovf_p3  <= 1'b0;
        end else if (en_p3 && vld_p2) begin
            sum_p3  <= p_p2 ^ c[WIDTH-1:0];
            cout_p3 <= c[WIDTH];
            ovf_p3  <= c[WIDTH] ^ c[WIDTH-1];
        end
    end

    assign out_sum  = sum_p3;
    assign out_cout = cout_p3;
    assign out_ovf  = ovf_p3;

endmodule

// File: tb/tb_bk_pipe_adder.sv
module tb_bk_pipe_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    always #5 clk = ~clk;

    bk_pipe_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        res_t         exp;
    } vec_t;

    res_t sb[$];
    res_t exp_next;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vt[12];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic [W:0]   t;
        res_t         r;
        bb     = sub ? ~b : b;
        t      = {1'b0, a} + {1'b0, bb} + (W+1)'(sub | cin);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == bb[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Scoreboard: retire before accept so a full pipe that swaps beats stays ordered.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                check("beat_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    res_t e;
                    e = sb.pop_front();
                    check("sum",  64'(out_sum),  64'(e.sum));
                    check("cout", 64'(out_cout), 64'(e.cout));
                    check("ovf",  64'(out_ovf),  64'(e.ovf));
                end
            end
            if (in_valid && in_ready) sb.push_back(exp_next);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input res_t e);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        exp_next = e;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(input int limit);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < limit) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end
        check("accept_in_time", 64'(acc), 64'd1);
    endtask

    task automatic send_vec(input vec_t v);
        drive(v.a, v.b, v.cin, v.sub, v.exp);
        wait_accept(20);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check("drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   acc_cnt;
        int   cyc;
        logic acc;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        vt[0]  = '{16'h8194, 16'h1314, 1'b0, 1'b0, '{16'h94A8, 1'b0, 1'b0}};
        vt[1]  = '{16'h52A0, 16'h9A44, 1'b0, 1'b0, '{16'hECE4, 1'b0, 1'b0}};
        vt[2]  = '{16'hB904, 16'hC6B4, 1'b0, 1'b0, '{16'h7FB8, 1'b1, 1'b1}};
        vt[3]  = '{16'h158A, 16'h7094, 1'b1, 1'b0, '{16'h861F, 1'b0, 1'b1}};
        vt[4]  = '{16'h1314, 16'h8194, 1'b1, 1'b1, '{16'h9180, 1'b0, 1'b1}};
        vt[5]  = '{16'h0005, 16'h0005, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
        vt[6]  = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, '{16'h0001, 1'b1, 1'b0}};
        vt[7]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
        vt[8]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
        vt[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
        vt[10] = '{16'h0000, 16'h0001, 1'b0, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};
        vt[11] = '{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        exp_next  = '0;

        // Reset state
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum",   64'(out_sum),   64'd0);
        check("rst_out_cout",  64'(out_cout),  64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 64'(in_ready), 64'd1);

        // T1: single beat latency
        send_vec(vt[0]);
        check("t1_lat_c1", 64'(out_valid), 64'd0);
        tick();
        check("t1_lat_c2", 64'(out_valid), 64'd0);
        tick();
        check("t1_lat_c3", 64'(out_valid), 64'd1);
        check("t1_sum",    64'(out_sum),   64'h94A8);
        drain(10);

        // T2/T3 and edge vectors, back to back
        for (int i = 0; i < 12; i++) send_vec(vt[i]);
        drain(20);

        // T4: backpressure, 3 buffered, 4th refused until release
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send_vec(vt[i]);
        drive(vt[4].a, vt[4].b, vt[4].cin, vt[4].sub, vt[4].exp);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t4_in_ready_low", 64'(in_ready),  64'd0);
            check("t4_out_valid",    64'(out_valid), 64'd1);
            check("t4_sum_held",     64'(out_sum),   64'(vt[1].exp.sum));
            tick();
        end
        out_ready = 1'b1;
        wait_accept(10);
        in_valid = 1'b0;
        drain(20);

        // T5: reset with beats in flight
        out_ready = 1'b0;
        for (int i = 7; i <= 9; i++) send_vec(vt[i]);
        rst = 1'b1;
        #1;
        check("t5_out_valid_rst", 64'(out_valid), 64'd0);
        check("t5_out_sum_rst",   64'(out_sum),   64'd0);
        sb.delete();
        tick();
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t5_no_stale", 64'(out_valid), 64'd0);
        end
        tick();
        send_vec(vt[6]);
        drain(10);

        // T6: random traffic with random valid/ready
        acc_cnt  = 0;
        cyc      = 0;
        in_valid = 1'b0;
        while (acc_cnt < 2000 && cyc < 20000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) acc_cnt++;
            tick();
            cyc++;
            if (acc || !in_valid) begin
                if ($urandom_range(0, 3) != 0) begin
                    ra = W'($urandom);
                    rb = W'($urandom);
                    rc = 1'($urandom);
                    rs = 1'($urandom);
                    drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t6_progress", 64'(acc_cnt), 64'd2000);
        drain(50);

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
